pool_sched: RTL and testbench

- Sequencer for the 2x2 max-pooling lane array.
- Walks one feature map per channel, two input rows at a time:
  - issues paired row reads to the feature-map buffer,
  - drives the pool array's mode code and per-lane enable for one cycle,
  - waits out the array latency,
  - writes one pooled row to the output buffer under a ready handshake.
- Sits between the layer-level control FSM (start/done) and the pooling datapath plus its buffers.

---
 rtl/pool_pkg.sv | 30 +++
 rtl/pool_addr_gen.sv | 55 +++++
 rtl/pool_sched.sv | 165 ++++++++++++++++
 tb/tb_pool_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 max-pooling sequencer.
// POOL_SCHED_PERF_EN (see pool_sched) adds a write-stall counter output.
package pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT_RD,
    POOL,
    WAIT_MAX,
    WRITE,
    DONE
  } state_e;

  localparam logic [3:0] CS_IDLE = 4'h0;
  localparam logic [3:0] SPOOL_1 = 4'h1;

  localparam int unsigned MASK_W = 64;

  // Lane mask with the lowest n bits set; callers truncate to their lane count.
  function automatic logic [MASK_W-1:0] mask(input int unsigned n);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Channel/row counters and row-address arithmetic for pool_sched.
// Row is the inner loop; the last flag marks the final row of the final channel.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int unsigned FM_H   = 28,
  parameter int unsigned CH     = 6,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic              last,
  output logic [ADDR_W-1:0] rd_addr_top,
  output logic [ADDR_W-1:0] rd_addr_bot,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int unsigned ROWS  = FM_H / 2;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;

  logic [CH_W-1:0]  ch;
  logic [ROW_W-1:0] row;

  logic row_last;
  logic ch_last;

  assign row_last = (row == ROW_W'(ROWS - 1));
  assign ch_last  = (ch == CH_W'(CH - 1));
  assign last     = row_last && ch_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch  <= '0;
      row <= '0;
    end else if (clr) begin
      ch  <= '0;
      row <= '0;
    end else if (adv) begin
      if (row_last) begin
        row <= '0;
        ch  <= ch_last ? '0 : ch + CH_W'(1);
      end else begin
        row <= row + ROW_W'(1);
      end
    end
  end

  assign rd_addr_top = ADDR_W'(32'(ch) * 32'(FM_H) + 32'(row) * 32'd2);
  assign rd_addr_bot = rd_addr_top + ADDR_W'(1);
  assign wr_addr     = ADDR_W'(32'(ch) * 32'(ROWS) + 32'(row));

endmodule

// File: rtl/pool_sched.sv
// Row sequencer for the 2x2 max-pooling lane array: read pair, pool, write.
// Optional macro POOL_SCHED_PERF_EN adds stall_cnt (WRITE cycles without wr_ready).
module pool_sched
  import pool_pkg::*;
#(
  parameter int unsigned FM_W    = 28,
  parameter int unsigned FM_H    = 28,
  parameter int unsigned CH      = 6,
  parameter int unsigned MAX_NUM = 16,
  parameter int unsigned MAX_LAT = 1,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr_top,
  output logic [ADDR_W-1:0]  rd_addr_bot,
  output logic [3:0]         cs,
  output logic [MAX_NUM-1:0] max_en,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  input  logic               wr_ready
`ifdef POOL_SCHED_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  if ((FM_W % 2) != 0 || (FM_W / 2) > MAX_NUM || MAX_NUM > MASK_W || FM_H < 2 ||
      CH < 1 || RD_LAT < 1 || MAX_LAT < 1 ||
      (64'(CH) * 64'(FM_H)) > (64'd1 << ADDR_W)) begin : g_param_check
    $error("pool_sched: illegal parameter combination");
  end

  localparam int unsigned LAT_MAX = (RD_LAT > MAX_LAT) ? RD_LAT : MAX_LAT;
  localparam int unsigned LAT_W   = $clog2(LAT_MAX + 1);
  localparam logic [MAX_NUM-1:0] LANE_MASK = MAX_NUM'(mask(FM_W / 2));

  state_e           state;
  logic [LAT_W-1:0] lat_cnt;

  logic              accept;
  logic              adv;
  logic              last_row;
  logic [ADDR_W-1:0] ag_top;
  logic [ADDR_W-1:0] ag_bot;
  logic [ADDR_W-1:0] ag_wr;

  assign accept = (state == IDLE) && start;
  assign adv    = (state == WRITE) && wr_ready;

  pool_addr_gen #(
    .FM_H  (FM_H),
    .CH    (CH),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept),
    .adv        (adv),
    .last       (last_row),
    .rd_addr_top(ag_top),
    .rd_addr_bot(ag_bot),
    .wr_addr    (ag_wr)
  );

  // Addresses are qualified by their strobes so every output idles at zero.
  assign rd_addr_top = rd_en ? ag_top : '0;
  assign rd_addr_bot = rd_en ? ag_bot : '0;
  assign wr_addr     = wr_en ? ag_wr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      lat_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      cs      <= CS_IDLE;
      max_en  <= '0;
      wr_en   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
            cs    <= SPOOL_1;
            rd_en <= 1'b1;
          end
        end
        READ: begin
          rd_en   <= 1'b0;
          lat_cnt <= LAT_W'(RD_LAT - 1);
          state   <= WAIT_RD;
        end
        WAIT_RD: begin
          if (lat_cnt == '0) begin
            state  <= POOL;
            max_en <= LANE_MASK;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        POOL: begin
          max_en  <= '0;
          lat_cnt <= LAT_W'(MAX_LAT - 1);
          state   <= WAIT_MAX;
        end
        WAIT_MAX: begin
          if (lat_cnt == '0) begin
            state <= WRITE;
            wr_en <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (last_row) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= READ;
              rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          cs    <= CS_IDLE;
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done   <= 1'b0;
          rd_en  <= 1'b0;
          cs     <= CS_IDLE;
          max_en <= '0;
          wr_en  <= 1'b0;
        end
      endcase
    end
  end

`ifdef POOL_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (state == WRITE && !wr_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool_sched.sv
// Self-checking bench for pool_sched: event-timeline model plus directed scenarios.
// Builds with or without POOL_SCHED_PERF_EN.
module tb_pool_sched;

  localparam int unsigned FM_H    = 28;
  localparam int unsigned CH      = 6;
  localparam int unsigned MAX_NUM = 16;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAX_LAT = 1;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned ROWS    = FM_H / 2;
  localparam int unsigned TOTAL   = CH * ROWS;
  localparam logic [3:0]  CS_IDLE_V = 4'h0;
  localparam logic [3:0]  SPOOL_V   = 4'h1;
  localparam logic [MAX_NUM-1:0] MASK_V = 16'h3FFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, wr_ready;
  logic               busy, done, rd_en, wr_en;
  logic [ADDR_W-1:0]  rd_addr_top, rd_addr_bot, wr_addr;
  logic [3:0]         cs;
  logic [MAX_NUM-1:0] max_en;
`ifdef POOL_SCHED_PERF_EN
  logic [31:0]        stall_cnt;
  logic [31:0]        b_stall_cnt;
`endif

  logic               b_start, b_wr_ready;
  logic               b_busy, b_done, b_rd_en, b_wr_en;
  logic [ADDR_W-1:0]  b_rd_top, b_rd_bot, b_wr_addr;
  logic [3:0]         b_cs;
  logic [MAX_NUM-1:0] b_max_en;

  pool_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_top(rd_addr_top), .rd_addr_bot(rd_addr_bot),
    .cs(cs), .max_en(max_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_ready(wr_ready)
`ifdef POOL_SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  pool_sched #(.FM_H(5), .CH(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .rd_en(b_rd_en), .rd_addr_top(b_rd_top), .rd_addr_bot(b_rd_bot),
    .cs(b_cs), .max_en(b_max_en), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_ready(b_wr_ready)
`ifdef POOL_SCHED_PERF_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Model: expectations are scheduled from events (start, read, handshake).
  int cyc = 0;
  bit busy_m = 0, rd_next = 0, done_next = 0, wr_phase = 0;
  int max_at = -1, wr_from = -1;
  int k = 0, nrd = 0, done_total = 0, dut_wr_cnt = 0, wr3_cycles = 0;
  bit seen_rd = 0, prev_busy = 0;
  int first_top = -1, first_bot = -1, last_top = -1, last_bot = -1;
  int busy_rise_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    bit exp_rd, exp_done, exp_max, exp_wr;
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_max_en", max_en, 0);
      chk("rst_cs", cs, CS_IDLE_V);
      chk("rst_rd_top", rd_addr_top, 0);
      chk("rst_rd_bot", rd_addr_bot, 0);
      chk("rst_wr_addr", wr_addr, 0);
      busy_m = 0; rd_next = 0; done_next = 0; wr_phase = 0;
      max_at = -1; wr_from = -1;
    end else begin
      exp_rd   = rd_next;
      exp_done = done_next;
      exp_max  = (cyc == max_at);
      if (cyc == wr_from) wr_phase = 1;
      exp_wr   = wr_phase;

      chk("busy", busy, busy_m);
      chk("cs", cs, busy_m ? SPOOL_V : CS_IDLE_V);
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        chk("rd_top", rd_addr_top, (nrd / ROWS) * FM_H + 2 * (nrd % ROWS));
        chk("rd_bot", rd_addr_bot, (nrd / ROWS) * FM_H + 2 * (nrd % ROWS) + 1);
      end
      chk("max_en", max_en, exp_max ? MASK_V : '0);
      chk("wr_en", wr_en, exp_wr);
      if (exp_wr) chk("wr_addr", wr_addr, k);
      chk("done", done, exp_done);

      if (rd_en) begin
        if (!seen_rd) begin
          first_top = int'(rd_addr_top);
          first_bot = int'(rd_addr_bot);
          seen_rd = 1;
        end
        last_top = int'(rd_addr_top);
        last_bot = int'(rd_addr_bot);
      end
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (done) done_cyc = cyc;
      if (wr_en && wr_addr == 3) wr3_cycles++;
      if (wr_en && wr_ready) dut_wr_cnt++;

      rd_next = 0;
      done_next = 0;
      if (exp_rd) begin
        max_at  = cyc + 1 + RD_LAT;
        wr_from = cyc + 2 + RD_LAT + MAX_LAT;
        nrd++;
      end
      if (exp_wr && wr_ready) begin
        wr_phase = 0;
        k++;
        if (k == TOTAL) done_next = 1;
        else rd_next = 1;
      end
      if (exp_done) begin
        busy_m = 0;
        done_total++;
      end else if (!busy_m && start) begin
        busy_m = 1; rd_next = 1; k = 0; nrd = 0; seen_rd = 0;
        wr3_cycles = 0; dut_wr_cnt = 0;
      end
    end
    prev_busy = busy;
    cyc++;
  end

  int b_wr_q[$];
  int b_nrd = 0, b_done_cnt = 0;
  bit b_row4 = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (b_wr_en && b_wr_ready) b_wr_q.push_back(int'(b_wr_addr));
      if (b_rd_en) begin
        b_nrd++;
        if (b_rd_top == 4 || b_rd_bot == 4) b_row4 = 1;
      end
      if (b_done) b_done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  initial begin
    bit ok, found;
    rst = 1'b1; start = 1'b0; wr_ready = 1'b1; b_start = 1'b0; b_wr_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Run 1: clean pass, stray starts while busy and in the done cycle.
    pulse_start();
    chk("busy_rise", busy, 1);
    repeat (40) tick();
    pulse_start();
    wait_done(2000, ok);
    if (ok) pulse_start();
    @(negedge clk); #1;
    chk("run1_model_writes", k, 84);
    chk("run1_dut_writes", dut_wr_cnt, 84);
    chk("run1_done_count", done_total, 1);
    chk("run1_first_top", first_top, 0);
    chk("run1_first_bot", first_bot, 1);
    chk("run1_last_top", last_top, 166);
    chk("run1_last_bot", last_bot, 167);
    chk("run1_latency", done_cyc - busy_rise_cyc, 420);
    repeat (5) tick();
    chk("run1_idle_busy", busy, 0);

    // Run 2: stall row 3 for 7 cycles, then reset during WAIT_MAX of row 5.
    pulse_start();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (wr_en && wr_addr == 3) found = 1;
      else tick();
    end
    chk("found_row3", found, 1);
    wr_ready = 1'b0;
    repeat (7) tick();
    wr_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (rd_en && rd_addr_top == 10) found = 1;
    end
    chk("found_row5", found, 1);
    tick();
    tick();
    chk("row5_max_en", max_en, MASK_V);
    tick();
    chk("row3_wr_cycles", wr3_cycles, 8);
`ifdef POOL_SCHED_PERF_EN
    chk("stall_cnt", stall_cnt, 7);
`endif
    rst = 1'b0;
    #1;
    chk("async_rd_en", rd_en, 0);
    chk("async_wr_en", wr_en, 0);
    chk("async_max_en", max_en, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_cs", cs, CS_IDLE_V);
`ifdef POOL_SCHED_PERF_EN
    chk("async_stall_cnt", stall_cnt, 0);
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) tick();
    chk("run2_no_done", done_total, 1);

    // Run 3: restart after reset.
    pulse_start();
    wait_done(2000, ok);
    @(negedge clk); #1;
    chk("run3_first_top", first_top, 0);
    chk("run3_dut_writes", dut_wr_cnt, 84);
    chk("run3_done_count", done_total, 2);

    // Odd-height instance: FM_H=5, CH=1.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (b_done) ok = 1;
    end
    chk("b_done_seen", ok, 1);
    @(negedge clk); #1;
    chk("b_write_count", b_wr_q.size(), 2);
    if (b_wr_q.size() >= 2) begin
      chk("b_wr0", b_wr_q[0], 0);
      chk("b_wr1", b_wr_q[1], 1);
    end
    chk("b_reads", b_nrd, 2);
    chk("b_row4_read", b_row4, 0);
    chk("b_done_count", b_done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
